// File: rtl/simon_control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : simon_control_pkg
//  Description : Shared state encoding and phase-indicator constants for the
//                Simon game control FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
package simon_control_pkg;

    // Game phases, two-bit encoding shared with anything that decodes state
    typedef enum logic [1:0] {
        ST_INPUT    = 2'd0,
        ST_PLAYBACK = 2'd1,
        ST_REPEAT   = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    // One-hot phase indicator driven on mode_leds
    localparam logic [3:0] C_MODE_INPUT    = 4'b0001;
    localparam logic [3:0] C_MODE_PLAYBACK = 4'b0010;
    localparam logic [3:0] C_MODE_REPEAT   = 4'b0100;
    localparam logic [3:0] C_MODE_DONE     = 4'b1000;

    // Map a phase onto its indicator pattern
    function automatic logic [3:0] mode_of(input state_e s);
        logic [3:0] m;
        m = C_MODE_INPUT;
        case (s)
            ST_INPUT:    m = C_MODE_INPUT;
            ST_PLAYBACK: m = C_MODE_PLAYBACK;
            ST_REPEAT:   m = C_MODE_REPEAT;
            ST_DONE:     m = C_MODE_DONE;
            default:     m = C_MODE_INPUT;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/simon_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : simon_control_if
//  Description : Strobe/status bundle between the Simon control FSM and the
//                Simon datapath (plus the player step pulse).
//  Revision    : 1.0 - initial release
// ============================================================================
interface simon_control_if;
    // Player input
    logic       step;
    // Datapath status flags
    logic       is_legal;
    logic       correct_pattern;
    logic       is_last_element;
    // Datapath strobes
    logic       dp_reset;
    logic       scld;
    logic       rcld;
    logic       rcclr;
    logic       srld;
    logic       led_sel;
    logic [3:0] mode_leds;

    // Controller side
    modport master (
        input  step, is_legal, correct_pattern, is_last_element,
        output dp_reset, scld, rcld, rcclr, srld, led_sel, mode_leds
    );

    // Datapath / player side
    modport slave (
        output step, is_legal, correct_pattern, is_last_element,
        input  dp_reset, scld, rcld, rcclr, srld, led_sel, mode_leds
    );
endinterface
`default_nettype wire

// File: rtl/simon_hold_timer.sv
`default_nettype none
// ============================================================================
//  Module      : simon_hold_timer
//  Description : Per-element display timer. Counts 0..PLAY_HOLD-1 while
//                enabled and pulses tick on the last count; held at zero
//                whenever disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module simon_hold_timer #(
    parameter int PLAY_HOLD = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic en_i,
    output logic      tick_o
);

    localparam logic [7:0] C_LAST = 8'(PLAY_HOLD - 1);

    logic [7:0] hold_cnt_q;
    logic [7:0] hold_cnt_d;

    assign tick_o = en_i && (hold_cnt_q == C_LAST);

    // Wrap at the last count, park at zero when the display phase is inactive
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (!en_i || tick_o) begin
            hold_cnt_d = 8'd0;
        end else begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_q <= 8'd0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/simon_control.sv
`default_nettype none
// ============================================================================
//  Module      : simon_control
//  Description : Simon game control FSM. Sequences the datapath through
//                pattern input, playback, player repeat and game-over
//                display, and tracks the sequence length so the pattern
//                memory never overflows.
//  Revision    : 1.0 - initial release
// ============================================================================
module simon_control
    import simon_control_pkg::*;
#(
    parameter int PLAY_HOLD = 4,
    parameter int MAX_LEN   = 64
) (
    input  wire logic       clk,
    input  wire logic       reset,
    simon_control_if.master bus
);

    localparam logic [6:0] C_MAX_LEN = 7'(MAX_LEN);

    state_e     state_q;
    state_e     state_d;
    logic [6:0] seq_len_q;
    logic [6:0] seq_len_d;
    logic       hold_en;
    logic       hold_tick;

    // The timer only runs while an element is being shown
    assign hold_en = (state_q == ST_PLAYBACK) || (state_q == ST_DONE);

    simon_hold_timer #(
        .PLAY_HOLD (PLAY_HOLD)
    ) u_hold_timer (
        .clk    (clk),
        .reset  (reset),
        .en_i   (hold_en),
        .tick_o (hold_tick)
    );

    // Next-state and strobe decode; reset overrides every state action
    always_comb begin
        state_d       = state_q;
        seq_len_d     = seq_len_q;
        bus.dp_reset  = 1'b0;
        bus.scld      = 1'b0;
        bus.rcld      = 1'b0;
        bus.rcclr     = 1'b0;
        bus.srld      = 1'b0;
        bus.led_sel   = 1'b1;
        bus.mode_leds = mode_of(state_q);

        if (reset) begin
            bus.dp_reset  = 1'b1;
            bus.rcclr     = 1'b1;
            bus.mode_leds = C_MODE_INPUT;
            state_d       = ST_INPUT;
            seq_len_d     = 7'd0;
        end else begin
            case (state_q)
                ST_INPUT: begin
                    // Store the new element and immediately replay the sequence;
                    // the length guard keeps the memory from overflowing
                    if (bus.step && bus.is_legal && (seq_len_q < C_MAX_LEN)) begin
                        bus.srld  = 1'b1;
                        bus.scld  = 1'b1;
                        bus.rcclr = 1'b1;
                        seq_len_d = seq_len_q + 7'd1;
                        state_d   = ST_PLAYBACK;
                    end
                end
                ST_PLAYBACK: begin
                    bus.led_sel = 1'b0;
                    if (hold_tick) begin
                        if (bus.is_last_element) begin
                            bus.rcclr = 1'b1;
                            state_d   = ST_REPEAT;
                        end else begin
                            bus.rcld = 1'b1;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (bus.step) begin
                        if (!bus.correct_pattern) begin
                            bus.rcclr = 1'b1;
                            state_d   = ST_DONE;
                        end else if (bus.is_last_element) begin
                            bus.rcclr = 1'b1;
                            state_d   = (seq_len_q == C_MAX_LEN) ? ST_DONE : ST_INPUT;
                        end else begin
                            bus.rcld = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // Endless replay of the stored sequence until reset
                    bus.led_sel = 1'b0;
                    if (hold_tick) begin
                        if (bus.is_last_element) begin
                            bus.rcclr = 1'b1;
                        end else begin
                            bus.rcld = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_INPUT;
                end
            endcase
        end
    end

    // State and sequence-length registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_INPUT;
            seq_len_q <= 7'd0;
        end else begin
            state_q   <= state_d;
            seq_len_q <= seq_len_d;
        end
    end

endmodule
`default_nettype wire
